// File: rtl/noc_leaf_concentrator.sv
// M:1 leaf concentrator: per-client/per-VC upstream FIFOs with round-robin credit-gated arbitration,
// per-VC downstream FIFOs demuxed by packet select field. NOC_CONC_STATS_EN builds the stat counters.
module noc_leaf_concentrator #(
  parameter int M          = 4,
  parameter int VC_W       = 2,
  parameter int A_W        = 8,
  parameter int D_W        = 8,
  parameter int SEL_LSB    = 0,
  parameter int CL_DEPTH   = 4,
  parameter int UP_CREDITS = 3,
  parameter int DN_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [M-1:0][VC_W-1:0]         cl_rx_vc_target,
  input  logic [M-1:0][A_W+D_W-1:0]      cl_rx_packet,
  output logic [M-1:0][VC_W-1:0]         cl_rx_vc_credit_gnt,
  output logic [M-1:0][VC_W-1:0]         cl_tx_vc_target,
  output logic [M-1:0][A_W+D_W-1:0]      cl_tx_packet,
  input  logic [M-1:0][VC_W-1:0]         cl_tx_vc_credit_gnt,
  output logic [VC_W-1:0]                up_tx_vc_target,
  output logic [A_W+D_W-1:0]             up_tx_packet,
  input  logic [VC_W-1:0]                up_tx_vc_credit_gnt,
  input  logic [VC_W-1:0]                dn_rx_vc_target,
  input  logic [A_W+D_W-1:0]             dn_rx_packet,
  output logic [VC_W-1:0]                dn_rx_vc_credit_gnt,
  output logic [M-1:0][31:0]             stat_flits_up,
  output logic [31:0]                    stat_stall_cycles
);
  localparam int CL_W = $clog2(M);
  localparam int PW   = A_W + D_W;
  localparam int NQ   = M * VC_W;
  localparam int CP_W = $clog2(CL_DEPTH);
  localparam int CC_W = $clog2(CL_DEPTH + 1);
  localparam int DP_W = $clog2(DN_DEPTH);
  localparam int DC_W = $clog2(DN_DEPTH + 1);
  localparam int UC_W = $clog2(UP_CREDITS + 1);
  localparam int VP_W = (VC_W > 1) ? $clog2(VC_W) : 1;

  logic [PW-1:0]   up_head [NQ];
  logic [NQ-1:0]   up_nonempty, up_full, up_pop, up_elig;
  logic [PW-1:0]   dn_head [VC_W];
  logic [VC_W-1:0] dn_nonempty, dn_full, dn_pop;

  // Upstream queues: queue index = client * VC_W + vc, matching the packed credit-grant layout.
  for (genvar gi = 0; gi < NQ; gi++) begin : g_up_fifo
    logic [PW-1:0]   mem [CL_DEPTH];
    logic [CP_W-1:0] wr_ptr, rd_ptr;
    logic [CC_W-1:0] cnt;
    logic            push;
    assign up_full[gi]     = (cnt == CC_W'(CL_DEPTH));
    assign up_nonempty[gi] = (cnt != '0);
    assign up_head[gi]     = mem[rd_ptr];
    assign push            = cl_rx_vc_target[gi / VC_W][gi % VC_W] && !up_full[gi];
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cl_rx_packet[gi / VC_W];
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push)        wr_ptr <= (wr_ptr == CP_W'(CL_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        if (up_pop[gi])  rd_ptr <= (rd_ptr == CP_W'(CL_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        cnt <= cnt + CC_W'(push) - CC_W'(up_pop[gi]);
      end
    end
  end

  for (genvar gi = 0; gi < VC_W; gi++) begin : g_dn_fifo
    logic [PW-1:0]   mem [DN_DEPTH];
    logic [DP_W-1:0] wr_ptr, rd_ptr;
    logic [DC_W-1:0] cnt;
    logic            push;
    assign dn_full[gi]     = (cnt == DC_W'(DN_DEPTH));
    assign dn_nonempty[gi] = (cnt != '0);
    assign dn_head[gi]     = mem[rd_ptr];
    assign push            = dn_rx_vc_target[gi] && !dn_full[gi];
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= dn_rx_packet;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push)        wr_ptr <= (wr_ptr == DP_W'(DN_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        if (dn_pop[gi])  rd_ptr <= (rd_ptr == DP_W'(DN_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        cnt <= cnt + DC_W'(push) - DC_W'(dn_pop[gi]);
      end
    end
  end

  logic [UC_W-1:0] up_cred [VC_W];
  logic [CC_W-1:0] cl_cred [M][VC_W];
  logic [CL_W-1:0] rr_ptr, win_c, idx;
  logic [VP_W-1:0] win_v;
  logic            up_found;
  logic [VP_W-1:0] dn_rr [M];
  logic [VP_W-1:0] dn_win [M];
  logic [M-1:0][VC_W-1:0] dn_gnt;

  // Upstream arbiter: scan clients from rr_ptr, the last hit in a descending scan is the nearest.
  always_comb begin
    up_elig  = '0;
    up_found = 1'b0;
    win_c    = '0;
    win_v    = '0;
    idx      = '0;
    up_pop   = '0;
    for (int q = 0; q < NQ; q++) up_elig[q] = up_nonempty[q] && (up_cred[q % VC_W] != '0);
    for (int k = M - 1; k >= 0; k--) begin
      idx = rr_ptr + CL_W'(k);
      if (|up_elig[int'(idx) * VC_W +: VC_W]) begin
        up_found = 1'b1;
        win_c    = idx;
      end
    end
    for (int v = VC_W - 1; v >= 0; v--)
      if (up_elig[int'(win_c) * VC_W + v]) win_v = VP_W'(v);
    if (up_found) up_pop[int'(win_c) * VC_W + int'(win_v)] = 1'b1;
  end

  // Downstream: each VC head names one client, so only VCs aimed at the same client compete.
  always_comb begin
    int v;
    v      = 0;
    dn_gnt = '0;
    dn_pop = '0;
    for (int c = 0; c < M; c++) begin
      dn_win[c] = '0;
      for (int k = VC_W - 1; k >= 0; k--) begin
        v = (int'(dn_rr[c]) + k) % VC_W;
        if (dn_nonempty[v] && (int'(dn_head[v][SEL_LSB +: CL_W]) == c) && (cl_cred[c][v] != '0)) begin
          dn_gnt[c]    = '0;
          dn_gnt[c][v] = 1'b1;
          dn_win[c]    = VP_W'(v);
        end
      end
      dn_pop = dn_pop | dn_gnt[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      up_tx_vc_target     <= '0;
      up_tx_packet        <= '0;
      cl_rx_vc_credit_gnt <= '0;
      cl_tx_vc_target     <= '0;
      cl_tx_packet        <= '0;
      dn_rx_vc_credit_gnt <= '0;
      rr_ptr              <= '0;
      for (int v = 0; v < VC_W; v++) up_cred[v] <= UC_W'(UP_CREDITS);
      for (int c = 0; c < M; c++) begin
        dn_rr[c] <= '0;
        for (int v = 0; v < VC_W; v++) cl_cred[c][v] <= CC_W'(CL_DEPTH);
      end
    end else begin
      up_tx_vc_target <= '0;
      up_tx_packet    <= '0;
      if (up_found) begin
        up_tx_vc_target[win_v] <= 1'b1;
        up_tx_packet           <= up_head[int'(win_c) * VC_W + int'(win_v)];
        rr_ptr                 <= win_c + 1'b1;
      end
      cl_rx_vc_credit_gnt <= up_pop;
      dn_rx_vc_credit_gnt <= dn_pop;
      for (int v = 0; v < VC_W; v++) begin
        if (up_tx_vc_credit_gnt[v] && !(up_found && win_v == VP_W'(v))) begin
          if (up_cred[v] != UC_W'(UP_CREDITS)) up_cred[v] <= up_cred[v] + 1'b1;
        end else if (!up_tx_vc_credit_gnt[v] && up_found && win_v == VP_W'(v)) begin
          up_cred[v] <= up_cred[v] - 1'b1;
        end
      end
      for (int c = 0; c < M; c++) begin
        cl_tx_vc_target[c] <= dn_gnt[c];
        cl_tx_packet[c]    <= (|dn_gnt[c]) ? dn_head[dn_win[c]] : '0;
        if (|dn_gnt[c]) dn_rr[c] <= (int'(dn_win[c]) == VC_W - 1) ? '0 : dn_win[c] + 1'b1;
        for (int v = 0; v < VC_W; v++) begin
          if (cl_tx_vc_credit_gnt[c][v] && !dn_gnt[c][v]) begin
            if (cl_cred[c][v] != CC_W'(CL_DEPTH)) cl_cred[c][v] <= cl_cred[c][v] + 1'b1;
          end else if (!cl_tx_vc_credit_gnt[c][v] && dn_gnt[c][v]) begin
            cl_cred[c][v] <= cl_cred[c][v] - 1'b1;
          end
        end
      end
    end
  end

`ifdef NOC_CONC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_flits_up     <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (up_found) stat_flits_up[win_c] <= stat_flits_up[win_c] + 32'd1;
      if ((|up_nonempty) && !up_found) stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`else
  assign stat_flits_up     = '0;
  assign stat_stall_cycles = '0;
`endif

`ifndef SYNTHESIS
  // Protocol checks: one VC per flit, no overfilled queues, no credit returned beyond the pool.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < M; c++) assert ($onehot0(cl_rx_vc_target[c]));
      assert ($onehot0(dn_rx_vc_target));
      assert ((cl_rx_vc_target & up_full) == '0);
      assert ((dn_rx_vc_target & dn_full) == '0);
      for (int v = 0; v < VC_W; v++)
        assert (!(up_tx_vc_credit_gnt[v] && !(up_found && win_v == VP_W'(v)) &&
                  up_cred[v] == UC_W'(UP_CREDITS)));
    end
  end
`endif
endmodule

// File: tb/tb_noc_leaf_concentrator.sv
// Directed self-checking bench for noc_leaf_concentrator (M=4, 2 VCs, 16-bit packets, 3 tree credits).
`timescale 1ns/1ps
module tb_noc_leaf_concentrator;
  localparam int M = 4, VC_W = 2, PW = 16;

  logic clk = 1'b0;
  logic rst;
  logic [M-1:0][VC_W-1:0] cl_rx_vc_target, cl_rx_vc_credit_gnt;
  logic [M-1:0][PW-1:0]   cl_rx_packet, cl_tx_packet;
  logic [M-1:0][VC_W-1:0] cl_tx_vc_target, cl_tx_vc_credit_gnt;
  logic [VC_W-1:0]        up_tx_vc_target, up_tx_vc_credit_gnt;
  logic [PW-1:0]          up_tx_packet, dn_rx_packet;
  logic [VC_W-1:0]        dn_rx_vc_target, dn_rx_vc_credit_gnt;
  logic [M-1:0][31:0]     stat_flits_up;
  logic [31:0]            stat_stall_cycles;

  int nvec = 0;
  int nerr = 0;
  bit auto_ret = 1'b0;
  int cnt;

  always #5 clk = ~clk;

  noc_leaf_concentrator #(
    .M(4), .VC_W(2), .A_W(8), .D_W(8), .SEL_LSB(0),
    .CL_DEPTH(4), .UP_CREDITS(3), .DN_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cl_rx_vc_target(cl_rx_vc_target), .cl_rx_packet(cl_rx_packet),
    .cl_rx_vc_credit_gnt(cl_rx_vc_credit_gnt),
    .cl_tx_vc_target(cl_tx_vc_target), .cl_tx_packet(cl_tx_packet),
    .cl_tx_vc_credit_gnt(cl_tx_vc_credit_gnt),
    .up_tx_vc_target(up_tx_vc_target), .up_tx_packet(up_tx_packet),
    .up_tx_vc_credit_gnt(up_tx_vc_credit_gnt),
    .dn_rx_vc_target(dn_rx_vc_target), .dn_rx_packet(dn_rx_packet),
    .dn_rx_vc_credit_gnt(dn_rx_vc_credit_gnt),
    .stat_flits_up(stat_flits_up), .stat_stall_cycles(stat_stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    $display("vec %0d %s observed=%h expected=%h", nvec, tag, obs, exp);
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample 1ns after the edge; the tree model echoes each upward flit as a credit when enabled.
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_ret) up_tx_vc_credit_gnt = up_tx_vc_target;
  endtask

  task automatic do_reset();
    auto_ret            = 1'b0;
    cl_rx_vc_target     = '0;
    cl_rx_packet        = '0;
    cl_tx_vc_credit_gnt = '0;
    up_tx_vc_credit_gnt = '0;
    dn_rx_vc_target     = '0;
    dn_rx_packet        = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_up_vc", 32'(up_tx_vc_target), 32'h0);
    check("rst_up_pkt", 32'(up_tx_packet), 32'h0);
    check("rst_clrx_gnt", 32'(cl_rx_vc_credit_gnt), 32'h0);
    check("rst_cltx_vc", 32'(cl_tx_vc_target), 32'h0);
    check("rst_cltx_pkt0", 32'(cl_tx_packet[0]), 32'h0);
    check("rst_dn_gnt", 32'(dn_rx_vc_credit_gnt), 32'h0);
    check("rst_stall", stat_stall_cycles, 32'h0);
    check("rst_flits0", stat_flits_up[0], 32'h0);

    // Single flit from client 2 on VC 0
    cl_rx_vc_target[2] = 2'b01;
    cl_rx_packet[2]    = 16'hA502;
    step();
    cl_rx_vc_target = '0;
    check("single_t1_idle", 32'(up_tx_vc_target), 32'h0);
    step();
    check("single_up_vc", 32'(up_tx_vc_target), 32'h1);
    check("single_up_pkt", 32'(up_tx_packet), 32'hA502);
    check("single_cl_gnt", 32'(cl_rx_vc_credit_gnt), 32'h10);
    step();
    check("single_after_vc", 32'(up_tx_vc_target), 32'h0);
    check("single_after_gnt", 32'(cl_rx_vc_credit_gnt), 32'h0);

    // All four clients stream 4 flits on VC 0; expect strict 0,1,2,3 rotation, one per cycle
    do_reset();
    auto_ret = 1'b1;
    for (int cyc = 0; cyc <= 16; cyc++) begin
      for (int c = 0; c < M; c++) begin
        cl_rx_vc_target[c] = (cyc < 4) ? 2'b01 : 2'b00;
        cl_rx_packet[c]    = {4'hC, 4'(c), 4'h0, 4'(cyc)};
      end
      step();
      if (cyc >= 1) begin
        int k;
        k = cyc - 1;
        check($sformatf("rr_flit%0d", k), {14'h0, up_tx_vc_target, up_tx_packet},
              {14'h0, 2'b01, 4'hC, 4'(k % 4), 4'h0, 4'(k / 4)});
      end
    end
    cl_rx_vc_target = '0;
`ifdef NOC_CONC_STATS_EN
    for (int c = 0; c < M; c++) check($sformatf("rr_stat%0d", c), stat_flits_up[c], 32'd4);
`else
    for (int c = 0; c < M; c++) check($sformatf("rr_stat%0d", c), stat_flits_up[c], 32'd0);
`endif

    // Credit exhaustion: 5 flits queued, only 3 leave, one returned credit releases one more
    do_reset();
    cnt = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      cl_rx_vc_target[1] = (cyc < 5) ? 2'b01 : 2'b00;
      cl_rx_packet[1]    = 16'hB100 + 16'(cyc);
      step();
      if (up_tx_vc_target == 2'b01) cnt++;
    end
    check("cred_sent_count", cnt, 32'd3);
`ifdef NOC_CONC_STATS_EN
    check("cred_stall_count", stat_stall_cycles, 32'd8);
`endif
    up_tx_vc_credit_gnt = 2'b01;
    step();
    up_tx_vc_credit_gnt = 2'b00;
    check("cred_pulse_t1", 32'(up_tx_vc_target), 32'h0);
    step();
    check("cred_pulse_t2", {14'h0, up_tx_vc_target, up_tx_packet}, {14'h0, 2'b01, 16'hB103});
    step();
    check("cred_pulse_t3", 32'(up_tx_vc_target), 32'h0);

    // 100 cycles of send plus same-cycle credit return: never stalls
    do_reset();
    auto_ret = 1'b1;
    cnt = 0;
    for (int cyc = 0; cyc <= 101; cyc++) begin
      cl_rx_vc_target[0] = 2'b01;
      cl_rx_packet[0]    = 16'(cyc);
      step();
      if (cyc >= 1 && cyc <= 100 && up_tx_vc_target == 2'b01) cnt++;
    end
    cl_rx_vc_target = '0;
    check("steady_sent_count", cnt, 32'd100);
    check("steady_stall", stat_stall_cycles, 32'd0);

    // Downstream: exhaust client 1 VC 1 credits, then head-of-line blocking and release
    do_reset();
    for (int cyc = 0; cyc <= 4; cyc++) begin
      dn_rx_vc_target = (cyc < 4) ? 2'b10 : 2'b00;
      dn_rx_packet    = 16'hD001 | 16'(cyc << 4);
      step();
      if (cyc >= 1) begin
        check($sformatf("dn_fill%0d", cyc - 1), {14'h0, cl_tx_vc_target[1], cl_tx_packet[1]},
              {14'h0, 2'b10, 16'hD001 | 16'((cyc - 1) << 4)});
        check($sformatf("dn_fill_gnt%0d", cyc - 1), 32'(dn_rx_vc_credit_gnt), 32'h2);
      end
    end
    dn_rx_vc_target = 2'b10;
    dn_rx_packet    = 16'h1101;
    step();
    dn_rx_packet    = 16'h3303;
    step();
    dn_rx_vc_target = 2'b00;
    step();
    step();
    step();
    check("hol_cltx_idle", 32'(cl_tx_vc_target), 32'h0);
    check("hol_dngnt_idle", 32'(dn_rx_vc_credit_gnt), 32'h0);
    cl_tx_vc_credit_gnt[1] = 2'b10;
    step();
    cl_tx_vc_credit_gnt = '0;
    check("hol_rel_t1", 32'(cl_tx_vc_target), 32'h0);
    step();
    check("hol_cl1", {14'h0, cl_tx_vc_target[1], cl_tx_packet[1]}, {14'h0, 2'b10, 16'h1101});
    check("hol_cl1_dngnt", 32'(dn_rx_vc_credit_gnt), 32'h2);
    step();
    check("hol_cl3", {14'h0, cl_tx_vc_target[3], cl_tx_packet[3]}, {14'h0, 2'b10, 16'h3303});
    check("hol_cl3_only", 32'(cl_tx_vc_target), 32'h80);
    check("hol_cl3_dngnt", 32'(dn_rx_vc_credit_gnt), 32'h2);
    step();
    check("hol_done_dngnt", 32'(dn_rx_vc_credit_gnt), 32'h0);

    // Reset mid-traffic with queues partly full
    do_reset();
    for (int cyc = 0; cyc < 2; cyc++) begin
      for (int c = 0; c < M; c++) begin
        cl_rx_vc_target[c] = 2'b10;
        cl_rx_packet[c]    = {8'hE0, 4'(c), 4'(cyc)};
      end
      step();
    end
    cl_rx_vc_target = '0;
    step();
    rst = 1'b1;
    step();
    check("mid_rst_up_vc", 32'(up_tx_vc_target), 32'h0);
    check("mid_rst_up_pkt", 32'(up_tx_packet), 32'h0);
    check("mid_rst_cl_gnt", 32'(cl_rx_vc_credit_gnt), 32'h0);
    check("mid_rst_stall", stat_stall_cycles, 32'h0);
    check("mid_rst_flits0", stat_flits_up[0], 32'h0);
    rst = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      step();
      if (up_tx_vc_target != '0 || cl_rx_vc_credit_gnt != '0) cnt++;
    end
    check("mid_rst_flushed", cnt, 32'd0);
    cl_rx_vc_target[3] = 2'b10;
    cl_rx_packet[3]    = 16'h7733;
    step();
    cl_rx_vc_target = '0;
    step();
    check("post_rst_flit", {14'h0, up_tx_vc_target, up_tx_packet}, {14'h0, 2'b10, 16'h7733});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
